// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer for the fetch stage.
//
// The block keeps the fetch PC and has no adder of its own. It steers one shared
// external adder:
//   - For a sequential fetch it sends pc and 4.
//   - For a branch, jal or jalr redirect it sends br_pc and br_imm.
// The result returns on add_sum and is the only way pc changes.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN): a redirect to a target that is not
// word aligned is still accepted and loaded. It then sets a sticky misalign flag and
// parks the FSM in HALT until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   fetch_ready  fetch stage consumes pc this cycle when pc_valid=1
//   pc_valid     pc holds a fetchable address
//   pc           current fetch address
//   br_req       redirect request
//   br_pc        redirect base operand
//   br_imm       redirect offset operand
//   br_ack       redirect accepted this cycle (combinational)
//   add_a        shared adder current_pc operand (combinational)
//   add_b        shared adder imm_val operand (combinational)
//   add_sum      shared adder next_address result
//   misalign     sticky misaligned-target flag (PC_MISALIGN_TRAP_EN only)
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  output logic        pc_valid,
  output logic [31:0] pc,
  input  logic        br_req,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_imm,
  output logic        br_ack,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

`ifdef PC_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot, StRun, StFlush, StHalt} state_e;
`else
  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic redirect_state;

  // Redirects are accepted only in RUN or FLUSH.
  // While reset is asserted they are always refused.
  assign redirect_state = (state_q == StRun) || (state_q == StFlush);
  assign br_ack         = rst_n && br_req && redirect_state;

  // Operand mux for the shared adder.
  // During reset it presents RESET_VECTOR + 4, whatever pc_q holds.
  always_comb begin
    add_a = pc_q;
    add_b = 32'd4;
    if (!rst_n) begin
      add_a = RESET_VECTOR;
    end else if (br_ack) begin
      add_a = br_pc;
      add_b = br_imm;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (br_ack) begin
      // The redirect always wins the pc update, even when the fetch of the
      // current pc completes in the same cycle.
      pc_d       = add_sum;
      pc_valid_d = 1'b0;
      state_d    = StFlush;
`ifdef PC_MISALIGN_TRAP_EN
      if (add_sum[1:0] != 2'b00) begin
        state_d    = StHalt;
        misalign_d = 1'b1;
      end
`endif
    end else begin
      unique case (state_q)
        StBoot: begin
          state_d    = StRun;
          pc_valid_d = 1'b1;
        end
        StRun: begin
          if (pc_valid_q && fetch_ready) begin
            pc_d = add_sum;
          end
        end
        StFlush: begin
          state_d    = StRun;
          pc_valid_d = 1'b1;
        end
`ifdef PC_MISALIGN_TRAP_EN
        StHalt: begin
          pc_valid_d = 1'b0;
        end
`endif
        default: begin
          state_d    = StBoot;
          pc_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed testbench for pc_seq_ctrl.
// The bench models the shared adder as a plain 32-bit sum.
// All expected values are hand-computed constants.
module tb_pc_seq_ctrl;

  localparam logic [31:0] Rv = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic        pc_valid;
  logic [31:0] pc;
  logic        br_req;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        br_ack;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int unsigned n_checks;
  int unsigned n_fails;

  pc_seq_ctrl #(
    .RESET_VECTOR(Rv)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_ready(fetch_ready),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .br_req     (br_req),
    .br_pc      (br_pc),
    .br_imm     (br_imm),
    .br_ack     (br_ack),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  // Shared adder: modulo 2^32, carry discarded.
  assign add_sum = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    rst_n       = 1'b0;
    fetch_ready = 1'b1;
    br_req      = 1'b1;
    br_pc       = 32'h0000_5555;
    br_imm      = 32'h0000_0010;
    #1;

    // In reset, redirects are refused and the adder sees RESET_VECTOR + 4.
    check_eq("rst_br_ack", {31'd0, br_ack}, 32'd0);
    check_eq("rst_add_a", add_a, Rv);
    check_eq("rst_add_b", add_b, 32'd4);
    step();
    step();
    check_eq("rst_pc", pc, Rv);
    check_eq("rst_valid", {31'd0, pc_valid}, 32'd0);
    check_eq("rst_add_a_after", add_a, Rv);

    // Release reset. BOOT lasts one cycle and ignores br_req.
    rst_n = 1'b1;
    #1;
    check_eq("boot_br_ack", {31'd0, br_ack}, 32'd0);
    check_eq("boot_valid", {31'd0, pc_valid}, 32'd0);
    br_req = 1'b0;
    step();
    check_eq("run_pc0", pc, 32'h0000_1000);
    check_eq("run_valid0", {31'd0, pc_valid}, 32'd1);
    step();
    check_eq("run_pc1", pc, 32'h0000_1004);
    step();
    check_eq("run_pc2", pc, 32'h0000_1008);

    // Stall for three cycles at 0x1008.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall_add_b", add_b, 32'd4);
      step();
      check_eq("stall_pc", pc, 32'h0000_1008);
      check_eq("stall_valid", {31'd0, pc_valid}, 32'd1);
    end

    // Redirect in the same cycle as a completing fetch.
    fetch_ready = 1'b1;
    br_req      = 1'b1;
    br_pc       = 32'h0000_1004;
    br_imm      = 32'hFFFF_FFF8;
    #1;
    check_eq("simul_br_ack", {31'd0, br_ack}, 32'd1);
    check_eq("simul_add_a", add_a, 32'h0000_1004);
    check_eq("simul_add_b", add_b, 32'hFFFF_FFF8);
    step();
    br_req = 1'b0;
    #1;
    check_eq("simul_pc", pc, 32'h0000_0FFC);
    check_eq("simul_flush_valid", {31'd0, pc_valid}, 32'd0);
    step();
    check_eq("simul_run_pc", pc, 32'h0000_0FFC);
    check_eq("simul_run_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check_eq("simul_next_pc", pc, 32'h0000_1000);

    // Back-to-back redirects, with the second one wrapping at 2^32.
    br_req = 1'b1;
    br_pc  = 32'h0000_3000;
    br_imm = 32'h0000_0010;
    #1;
    check_eq("b2b_ack1", {31'd0, br_ack}, 32'd1);
    step();
    check_eq("b2b_pc1", pc, 32'h0000_3010);
    br_pc  = 32'hFFFF_FFF8;
    br_imm = 32'h0000_0004;
    #1;
    check_eq("b2b_ack2_flush", {31'd0, br_ack}, 32'd1);
    step();
    br_req = 1'b0;
    #1;
    check_eq("b2b_pc2", pc, 32'hFFFF_FFFC);
    check_eq("b2b_valid2", {31'd0, pc_valid}, 32'd0);
    step();
    check_eq("b2b_run_pc", pc, 32'hFFFF_FFFC);
    check_eq("b2b_run_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check_eq("wrap_pc", pc, 32'h0000_0000);
    check_eq("wrap_valid", {31'd0, pc_valid}, 32'd1);

    // Redirect to a target that is not word aligned.
    br_req = 1'b1;
    br_pc  = 32'h0000_2000;
    br_imm = 32'h0000_0002;
    #1;
    check_eq("mis_ack", {31'd0, br_ack}, 32'd1);
    step();
    br_req = 1'b0;
    #1;
    check_eq("mis_pc", pc, 32'h0000_2002);
    check_eq("mis_valid0", {31'd0, pc_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("mis_flag", {31'd0, misalign}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      br_req = 1'b1;
      #1;
      check_eq("halt_br_ack", {31'd0, br_ack}, 32'd0);
      step();
      check_eq("halt_valid", {31'd0, pc_valid}, 32'd0);
      check_eq("halt_pc", pc, 32'h0000_2002);
      check_eq("halt_flag", {31'd0, misalign}, 32'd1);
    end
    br_req = 1'b0;
`else
    step();
    check_eq("mis_run_pc", pc, 32'h0000_2002);
    check_eq("mis_run_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check_eq("mis_next_pc", pc, 32'h0000_2006);
`endif

    // Reset asserted during a FLUSH cycle. Under the trap build this also
    // clears the trap.
`ifndef PC_MISALIGN_TRAP_EN
    br_req = 1'b1;
    br_pc  = 32'h0000_4000;
    br_imm = 32'h0000_0000;
    step();
    check_eq("mid_flush_pc", pc, 32'h0000_4000);
    check_eq("mid_flush_valid", {31'd0, pc_valid}, 32'd0);
`endif
    rst_n  = 1'b0;
    br_req = 1'b1;
    #1;
    check_eq("mid_rst_br_ack", {31'd0, br_ack}, 32'd0);
    check_eq("mid_rst_add_a", add_a, Rv);
    check_eq("mid_rst_add_b", add_b, 32'd4);
    step();
    check_eq("mid_rst_pc", pc, Rv);
    check_eq("mid_rst_valid", {31'd0, pc_valid}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("mid_rst_misalign", {31'd0, misalign}, 32'd0);
`endif
    // Back in BOOT: br_req is ignored, then RUN resumes at RESET_VECTOR.
    rst_n = 1'b1;
    #1;
    check_eq("reboot_br_ack", {31'd0, br_ack}, 32'd0);
    br_req = 1'b0;
    step();
    check_eq("reboot_pc", pc, Rv);
    check_eq("reboot_valid", {31'd0, pc_valid}, 32'd1);
    step();
    check_eq("reboot_pc_next", pc, 32'h0000_1004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 The parameter SHALL be RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- fetch_ready  input  1  fetch stage consumes pc this cycle when pc_valid=1.
- pc_valid  output  1  pc holds a fetchable address.
- pc  output  32  current fetch address.
- br_req  input  1  redirect request (branch, jal or jalr resolved).
- br_pc  input  32  base operand of the redirect.
- br_imm  input  32  offset operand of the redirect.
- br_ack  output  1  redirect accepted this cycle.
- add_a  output  32  to the shared adder's current_pc input.
- add_b  output  32  to the shared adder's imm_val input.
- add_sum  input  32  from the shared adder's next_address output.
- misalign  output  1  sticky misaligned-target flag; present only under REQ-019.

Function
REQ-004 The FSM SHALL have states BOOT, RUN and FLUSH, plus HALT only under REQ-019.
REQ-005 The operand mux SHALL be combinational:
- if br_req=1 and state is RUN or FLUSH: add_a=br_pc, add_b=br_imm;
- otherwise: add_a=pc, add_b=32'd4.
REQ-006 Only add_sum SHALL be used to compute the next pc; the block SHALL contain no internal adder for the pc.
REQ-007 br_ack SHALL be combinational: br_ack = br_req AND (state is RUN or FLUSH).
REQ-008 BOOT: pc_valid=0 and br_req is ignored (br_ack=0); the next state is RUN unconditionally after exactly one cycle.
REQ-009 RUN with br_ack=1:
- pc <= add_sum and the next state is FLUSH;
- pc_valid is registered 0 for the next cycle.
REQ-010 RUN with br_req=0, pc_valid=1 and fetch_ready=1: pc <= add_sum (pc+4); pc_valid stays 1.
REQ-011 RUN with br_req=0 and fetch_ready=0: pc and pc_valid SHALL hold (stall of any length).
REQ-012 If br_req and fetch_ready are both 1 in RUN:
- the fetch of the current pc completes;
- pc loads the redirect target (the redirect wins the pc update).
REQ-013 FLUSH with br_ack=1 (back-to-back redirect): pc <= add_sum, stay in FLUSH, pc_valid=0.
REQ-014 FLUSH with br_req=0: pc holds; next state is RUN with pc_valid=1.
REQ-015 All additions SHALL be modulo 2^32 with carry discarded: 32'hFFFF_FFFC+4 yields 32'h0000_0000, and no flag is raised.
REQ-016 pc, pc_valid and state SHALL be registered; only add_a, add_b and br_ack are combinational.

Reset
REQ-017 When rst_n=0 at a rising edge:
- pc=RESET_VECTOR, pc_valid=0, state=BOOT, misalign=0;
- any in-progress redirect or stall is abandoned.
REQ-018 While rst_n=0: br_ack=0, add_a=RESET_VECTOR and add_b=4.

Configuration
REQ-019 Macro PC_MISALIGN_TRAP_EN:
- when defined, a redirect whose add_sum[1:0]!=2'b00 SHALL still be acked and loaded into pc;
- misalign is then set sticky, the FSM enters HALT, and pc_valid stays 0 until reset;
- br_req is ignored in HALT.
REQ-020 When PC_MISALIGN_TRAP_EN is undefined: there is no misalign port, no HALT state, and misaligned targets are loaded and fetched unchanged.

Verification
REQ-021 Reset-boot sequence:
- stimulus: RESET_VECTOR=32'h0000_1000, release rst_n, fetch_ready=1;
- required: pc_valid=0 for one cycle, then pc=0x1000, 0x1004, 0x1008 on successive cycles.
REQ-022 Stall:
- stimulus: fetch_ready=0 for 3 cycles at pc=0x1008;
- required: pc stays 0x1008, pc_valid stays 1, add_b=4.
REQ-023 Simultaneous redirect:
- stimulus: br_req=1, br_pc=0x1004, br_imm=32'hFFFF_FFF8 while fetch_ready=1;
- required: br_ack=1 in the same cycle, add_a=0x1004, then pc=0x0FFC with pc_valid=0 for one cycle, then 1.
REQ-024 Back-to-back redirect and wrap:
- stimulus: redirects in two consecutive cycles, the second with br_pc=0xFFFF_FFF8 and br_imm=4;
- required: pc=0xFFFF_FFFC after FLUSH, then 0x0000_0000 on the next fetch.
REQ-025 Misalignment trap (macro defined):
- stimulus: br_pc=0x2000, br_imm=2;
- required: br_ack=1, pc=0x2002, misalign=1, pc_valid held 0, and a later br_req gives br_ack=0.
REQ-026 Reset mid-redirect:
- stimulus: rst_n=0 in the FLUSH cycle;
- required: pc=RESET_VECTOR, state=BOOT, misalign=0.
